// File: rtl/row_sweep_controller_pkg.sv
// Shared types and defaults for the stacker row sweep controller.
package row_sweep_controller_pkg;

  localparam int unsigned COLS_DEF  = 8;
  localparam int unsigned ROWS_DEF  = 15;
  localparam int unsigned CNT_W_DEF = 26;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MOVE,
    S_DRAW,
    S_CHECK,
    S_TRIM_DRAW,
    S_REPORT
  } state_e;

  // Bar length limited to at least one cell and at most the board width.
  function automatic int unsigned clamp_len(input logic [3:0] n, input int unsigned cols);
    int unsigned v;
    v = 32'(n);
    if (v == 0) v = 1;
    else if (v > cols) v = cols;
    return v;
  endfunction

endpackage

// File: rtl/row_sweep_controller_sweep_tick_gen.sv
// Loadable period counter: tick_o marks the last clock of each sweep period.
module sweep_tick_gen #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q;

  assign tick_o = en_i && (cnt_q == period_q - CNT_W'(1));

  // Count enabled clocks, wrapping to zero on each tick; load restarts the period.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      period_q <= CNT_W'(1);
    end else if (load_i) begin
      cnt_q    <= '0;
      period_q <= period_i;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/row_sweep_controller.sv
// Sweeps one stacker row back and forth, hands each position to the drawer,
// trims the bar on drop and reports the outcome to the level sequencer.
module row_sweep_controller
  import row_sweep_controller_pkg::*;
#(
  parameter int unsigned COLS  = COLS_DEF,
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go,
  input  logic             drop,
  input  logic [CNT_W-1:0] speed_count,
  input  logic [3:0]       num_blocks,
  input  logic             draw_ack,
  output logic [COLS-1:0]  row_mask,
  output logic [COLS-1:0]  stack_mask,
  output logic [3:0]       row_idx,
  output logic             draw_req,
  output logic             next_signal,
  output logic             game_over,
  output logic             win,
  output logic             busy
);

  state_e          state_q;
  logic [COLS-1:0] row_mask_q, stack_mask_q;
  logic [3:0]      row_idx_q;
  logic            dir_up_q, full_q, drop_pend_q;
  logic            draw_req_q, next_q, game_over_q, win_q;

  logic [COLS-1:0]  load_mask_d, step_mask_d, ov_d;
  logic             step_dir_up_d, full_d;
  logic [CNT_W-1:0] period_d;
  int unsigned      len_d;
  logic             tick;

  sweep_tick_gen #(
    .CNT_W(CNT_W)
  ) u_tick (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (state_q == S_LOAD),
    .en_i    (state_q == S_MOVE),
    .period_i(period_d),
    .tick_o  (tick)
  );

  // Load pattern, next bounce position and overlap with the row below.
  always_comb begin
    len_d    = clamp_len(num_blocks, COLS);
    full_d   = (len_d == COLS);
    period_d = (speed_count == '0) ? CNT_W'(1) : speed_count;
    load_mask_d = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      load_mask_d[i] = (i < len_d);
    end
    step_mask_d   = row_mask_q;
    step_dir_up_d = dir_up_q;
    if (!full_q) begin
      if (dir_up_q) begin
        if (row_mask_q[COLS-1]) begin
          step_dir_up_d = 1'b0;
          step_mask_d   = row_mask_q >> 1;
        end else begin
          step_mask_d = row_mask_q << 1;
        end
      end else begin
        if (row_mask_q[0]) begin
          step_dir_up_d = 1'b1;
          step_mask_d   = row_mask_q << 1;
        end else begin
          step_mask_d = row_mask_q >> 1;
        end
      end
    end
    ov_d = row_mask_q & stack_mask_q;
  end

  // Row sequencing FSM with registered outputs and one-cycle result pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      row_mask_q   <= '0;
      stack_mask_q <= '1;
      row_idx_q    <= '0;
      dir_up_q     <= 1'b1;
      full_q       <= 1'b0;
      drop_pend_q  <= 1'b0;
      draw_req_q   <= 1'b0;
      next_q       <= 1'b0;
      game_over_q  <= 1'b0;
      win_q        <= 1'b0;
    end else begin
      next_q      <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
      drop_pend_q <= drop_pend_q | (drop && (state_q != S_IDLE));
      unique case (state_q)
        S_IDLE: begin
          if (go) state_q <= S_LOAD;
        end
        S_LOAD: begin
          row_mask_q <= load_mask_d;
          full_q     <= full_d;
          dir_up_q   <= 1'b1;
          draw_req_q <= 1'b1;
          state_q    <= S_DRAW;
        end
        S_MOVE: begin
          if (drop_pend_q) begin
            drop_pend_q <= 1'b0;
            state_q     <= S_CHECK;
          end else if (tick) begin
            row_mask_q <= step_mask_d;
            dir_up_q   <= step_dir_up_d;
            draw_req_q <= 1'b1;
            state_q    <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (draw_ack) begin
            draw_req_q <= 1'b0;
            state_q    <= S_MOVE;
          end
        end
        S_CHECK: begin
          if (ov_d == '0) begin
            game_over_q  <= 1'b1;
            row_idx_q    <= '0;
            stack_mask_q <= '1;
            row_mask_q   <= '0;
            state_q      <= S_IDLE;
          end else begin
            row_mask_q   <= ov_d;
            stack_mask_q <= ov_d;
            draw_req_q   <= 1'b1;
            state_q      <= S_TRIM_DRAW;
          end
        end
        S_TRIM_DRAW: begin
          if (draw_ack) begin
            draw_req_q <= 1'b0;
            state_q    <= S_REPORT;
          end
        end
        S_REPORT: begin
          next_q <= 1'b1;
          if (row_idx_q == 4'(ROWS - 1)) begin
            win_q        <= 1'b1;
            row_idx_q    <= '0;
            stack_mask_q <= '1;
          end else begin
            row_idx_q <= row_idx_q + 4'd1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign row_mask    = row_mask_q;
  assign stack_mask  = stack_mask_q;
  assign row_idx     = row_idx_q;
  assign draw_req    = draw_req_q;
  assign next_signal = next_q;
  assign game_over   = game_over_q;
  assign win         = win_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_row_sweep_controller.sv
// Directed bench for row_sweep_controller (COLS=8, ROWS=2).
module tb_row_sweep_controller;

  logic        clk = 1'b0;
  logic        resetn, go, drop, draw_ack;
  logic [25:0] speed_count;
  logic [3:0]  num_blocks;
  logic [7:0]  row_mask, stack_mask;
  logic [3:0]  row_idx;
  logic        draw_req, next_signal, game_over, win, busy;

  row_sweep_controller #(
    .COLS (8),
    .ROWS (2),
    .CNT_W(26)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .go         (go),
    .drop       (drop),
    .speed_count(speed_count),
    .num_blocks (num_blocks),
    .draw_ack   (draw_ack),
    .row_mask   (row_mask),
    .stack_mask (stack_mask),
    .row_idx    (row_idx),
    .draw_req   (draw_req),
    .next_signal(next_signal),
    .game_over  (game_over),
    .win        (win),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         nb;
    int         spd;
    int         drop_idx;
    logic [7:0] exp_drop_mask;
    bit         exp_trim;
    logic [7:0] exp_trim_mask;
    logic [7:0] exp_trim_stack;
    bit         exp_next;
    bit         exp_go;
    bit         exp_win;
    int         exp_idx;
    logic [7:0] exp_stack;
    logic [7:0] exp_row;
  } vec_t;

  vec_t tbl[6];

  logic [7:0] drawn[64];
  int         gaps[64];
  bit         tmo, trim_seen, got_next, got_go, got_win;
  logic [7:0] trim_mask, trim_stack, got_stack, got_row;
  int         got_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(output bit ok, output int gap);
    gap = 0;
    while (!draw_req && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    ok = draw_req;
  endtask

  // Start a row, acknowledge each drawn position, drop on draw number drop_idx,
  // then service the trim draw and capture the result pulse.
  task automatic play_row(input int nb, input int spd, input int drop_idx);
    bit ok;
    int gap;
    tmo = 0; trim_seen = 0; got_next = 0; got_go = 0; got_win = 0;
    num_blocks  = 4'(nb);
    speed_count = 26'(spd);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 0; k <= drop_idx; k++) begin
      wait_req(ok, gap);
      if (!ok) begin
        tmo = 1;
        break;
      end
      drawn[k] = row_mask;
      gaps[k]  = gap;
      draw_ack = 1'b1;
      if (k == drop_idx) drop = 1'b1;
      @(negedge clk);
      draw_ack = 1'b0;
      drop     = 1'b0;
    end
    tmo = 1;
    for (int c = 0; c < 60; c++) begin
      if (draw_req) begin
        trim_seen  = 1;
        trim_mask  = row_mask;
        trim_stack = stack_mask;
        draw_ack   = 1'b1;
        @(negedge clk);
        draw_ack   = 1'b0;
      end else if (next_signal || game_over || win) begin
        tmo = 0;
        break;
      end else begin
        @(negedge clk);
      end
    end
    got_next  = next_signal;
    got_go    = game_over;
    got_win   = win;
    got_idx   = int'(row_idx);
    got_stack = stack_mask;
    got_row   = row_mask;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq1[8];
    bit ok, frozen;
    int gap;

    seq1 = '{8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70, 8'h38};
    //            nb spd drop  dmask  trim tmask  tstack nxt go win idx stack  row
    tbl[0] = '{3,  4,  8,   8'h1C, 1, 8'h1C, 8'h1C, 1, 0, 0, 1, 8'h1C, 8'h1C};
    tbl[1] = '{3,  1,  4,   8'h70, 1, 8'h10, 8'h10, 1, 0, 1, 0, 8'hFF, 8'h10};
    tbl[2] = '{2,  0,  0,   8'h03, 1, 8'h03, 8'h03, 1, 0, 0, 1, 8'h03, 8'h03};
    tbl[3] = '{3,  2,  5,   8'hE0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'hFF, 8'h00};
    tbl[4] = '{0,  0,  2,   8'h04, 1, 8'h04, 8'h04, 1, 0, 0, 1, 8'h04, 8'h04};
    tbl[5] = '{12, 0,  3,   8'hFF, 1, 8'h04, 8'h04, 1, 0, 1, 0, 8'hFF, 8'h04};

    resetn = 1'b0; go = 1'b0; drop = 1'b0; draw_ack = 1'b0;
    speed_count = '0; num_blocks = '0;
    repeat (2) @(negedge clk);
    chk("rst_row_mask", 32'(row_mask), 32'h00);
    chk("rst_stack", 32'(stack_mask), 32'hFF);
    chk("rst_row_idx", 32'(row_idx), 0);
    chk("rst_outs", {draw_req, next_signal, game_over, win, busy}, 0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      play_row(tbl[i].nb, tbl[i].spd, tbl[i].drop_idx);
      chk($sformatf("v%0d_timeout", i), 32'(tmo), 0);
      chk($sformatf("v%0d_drop_mask", i), 32'(drawn[tbl[i].drop_idx]), 32'(tbl[i].exp_drop_mask));
      chk($sformatf("v%0d_trim_seen", i), 32'(trim_seen), 32'(tbl[i].exp_trim));
      if (tbl[i].exp_trim) begin
        chk($sformatf("v%0d_trim_mask", i), 32'(trim_mask), 32'(tbl[i].exp_trim_mask));
        chk($sformatf("v%0d_trim_stack", i), 32'(trim_stack), 32'(tbl[i].exp_trim_stack));
      end
      chk($sformatf("v%0d_pulses", i), {got_next, got_go, got_win},
          {tbl[i].exp_next, tbl[i].exp_go, tbl[i].exp_win});
      chk($sformatf("v%0d_row_idx", i), 32'(got_idx), 32'(tbl[i].exp_idx));
      chk($sformatf("v%0d_stack", i), 32'(got_stack), 32'(tbl[i].exp_stack));
      chk($sformatf("v%0d_row", i), 32'(got_row), 32'(tbl[i].exp_row));
      if (i == 0) begin
        for (int k = 0; k < 8; k++) begin
          chk($sformatf("sweep_mask%0d", k), 32'(drawn[k]), 32'(seq1[k]));
          if (k > 0) chk($sformatf("sweep_gap%0d", k), 32'(gaps[k]), 4);
        end
      end
      if (i == 4) begin
        for (int k = 0; k < 3; k++)
          chk($sformatf("len1_gap%0d", k), 32'(k == 0 ? 1 : gaps[k]), 1);
      end
    end

    // Place row 0 so the reset sequence below starts from non-reset values.
    play_row(3, 0, 0);
    chk("pre_rst_stack", 32'(stack_mask), 32'h07);
    chk("pre_rst_idx", 32'(row_idx), 1);

    // Drawer stalls for 20 clocks; go pulses while busy must not disturb anything.
    num_blocks = 4'd3; speed_count = 26'd4;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_req(ok, gap);
    chk("stall_req_seen", 32'(ok), 1);
    frozen = 1;
    go = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (row_mask !== 8'h07 || draw_req !== 1'b1 || busy !== 1'b1) frozen = 0;
    end
    go = 1'b0;
    chk("stall_frozen", 32'(frozen), 1);
    draw_ack = 1'b1;
    @(negedge clk);
    draw_ack = 1'b0;
    @(negedge clk);
    chk("move_busy", {busy, draw_req}, 2'b10);

    // Asynchronous reset in the middle of MOVE.
    resetn = 1'b0;
    #1;
    chk("mid_rst_row_mask", 32'(row_mask), 32'h00);
    chk("mid_rst_stack", 32'(stack_mask), 32'hFF);
    chk("mid_rst_row_idx", 32'(row_idx), 0);
    chk("mid_rst_outs", {draw_req, next_signal, game_over, win, busy}, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // A drop while idle is ignored: the next row must stop at its second position.
    drop = 1'b1;
    @(negedge clk);
    drop = 1'b0;
    play_row(1, 0, 1);
    chk("idle_drop_timeout", 32'(tmo), 0);
    chk("idle_drop_trim", 32'(trim_mask), 32'h02);
    chk("idle_drop_stack", 32'(stack_mask), 32'h02);
    chk("idle_drop_idx", 32'(row_idx), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
